// File: rtl/cdma_pkg.sv
// Shared types and defaults for the CDMA frame synchroniser: FSM states,
// FIFO entry layout and the default parameter values.
package cdma_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  localparam logic [7:0] DEF_SYNC_WORD     = 8'hA5;
  localparam int         DEF_FIFO_DEPTH    = 4;
  localparam int         DEF_PAYLOAD_BYTES = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/cdma_frame_sync_if.sv
// Bit-stream input, byte-stream output and status signals of cdma_frame_sync.
// Output stream: a byte transfers on every cycle where out_valid && out_ready;
// out_data/out_last stay stable while out_valid is high and out_ready is low.
interface cdma_frame_sync_if;
  import cdma_pkg::*;

  logic       bit_in;
  logic       bit_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       in_sync;
  logic       sync_pulse;
  logic       overflow;
  logic [7:0] frame_count;
  state_e     state_dbg;

  modport master (
    output bit_in, bit_valid, out_ready,
    input  out_data, out_last, out_valid, in_sync, sync_pulse, overflow,
           frame_count, state_dbg
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output out_data, out_last, out_valid, in_sync, sync_pulse, overflow,
           frame_count, state_dbg
  );
endinterface

// File: rtl/cdma_byte_fifo.sv
// Small output FIFO of {last, byte} entries. A push into a full FIFO is
// accepted only if a pop happens in the same cycle; otherwise it is dropped.
module cdma_byte_fifo
  import cdma_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty,
  output logic        drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;

    // Head is forced to zero when empty so stale entries never show.
    dout = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/cdma_frame_sync.sv
// Frame synchroniser: hunts for SYNC_WORD in the despread bit stream, then
// packs the following PAYLOAD_BYTES bytes MSB-first into the output FIFO.
module cdma_frame_sync
  import cdma_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int         PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int         FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst,
  cdma_frame_sync_if.slave  bus
);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  state_e      state_q, state_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic        sync_pulse_q, sync_pulse_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [7:0]  shifted;
  logic        push, fifo_full, fifo_empty, fifo_drop;
  fifo_entry_t push_entry, head;

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    sync_pulse_d  = 1'b0;
    frame_count_d = frame_count_q;
    push          = 1'b0;
    push_entry    = '0;
    shifted       = {sreg_q[6:0], bus.bit_in};

    if (bus.bit_valid) begin
      sreg_d = shifted;
      case (state_q)
        HUNT: begin
          if (shifted == SYNC_WORD) begin
            state_d      = PAYLOAD;
            sync_pulse_d = 1'b1;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
          end
        end
        PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push            = 1'b1;
            push_entry.data = shifted;
            push_entry.last = (byte_cnt_q == LAST_IDX);
            byte_cnt_d      = byte_cnt_q + 8'd1;
            if (push_entry.last) begin
              // Clearing sreg keeps payload bits out of the next hunt.
              state_d       = HUNT;
              sreg_d        = '0;
              frame_count_d = frame_count_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      sync_pulse_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      sync_pulse_q  <= sync_pulse_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  cdma_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (bus.out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign bus.out_data    = head.data;
  assign bus.out_last    = head.last;
  assign bus.out_valid   = !fifo_empty;
  assign bus.in_sync     = (state_q == PAYLOAD);
  assign bus.sync_pulse  = sync_pulse_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_count = frame_count_q;
  assign bus.state_dbg   = state_q;

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: doc/cdma_frame_sync.md
CDMA_FRAME_SYNC -- requirements
Module: cdma_frame_sync

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5: frame marker searched for in the despread bit stream.
REQ-002 Parameter PAYLOAD_BYTES, default 4: number of payload bytes following each sync word (legal range 1..255).
REQ-003 Parameter FIFO_DEPTH, default 4: output byte buffer entries (power of two, >=2).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock shared with cdma_receiver.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 bit_in  input  1  despread data bit (cdma_receiver data_out).
REQ-008 bit_valid  input  1  one-cycle strobe qualifying bit_in (cdma_receiver data_valid).
REQ-009 out_data  output  8  payload byte at FIFO head.
REQ-010 out_last  output  1  head byte is the final byte of its frame.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts head byte when out_valid&&out_ready.
REQ-013 in_sync  output  1  high while in PAYLOAD state.
REQ-014 sync_pulse  output  1  one-cycle pulse on sync-word detection.
REQ-015 overflow  output  1  sticky: a completed byte was dropped because the FIFO was full.
REQ-016 frame_count  output  8  completed frames pushed, wraps 255->0.

Function
REQ-017 The FSM SHALL have exactly two states: HUNT and PAYLOAD; bits SHALL be taken only on cycles with bit_valid=1.
REQ-018 In HUNT, each valid bit SHALL shift into an 8-bit register MSB-first (sreg <= {sreg[6:0],bit_in}).
REQ-019 When the post-shift value equals SYNC_WORD, the FSM SHALL enter PAYLOAD next cycle, assert sync_pulse for one cycle, and clear bit and byte counters.
REQ-020 In PAYLOAD, bits SHALL assemble MSB-first; on the 8th bit the byte SHALL be pushed with out_last=1 iff byte index == PAYLOAD_BYTES-1.
REQ-021 After pushing the last byte the FSM SHALL return to HUNT with sreg cleared to 0 (no overlap of payload into hunt) and frame_count SHALL increment.
REQ-022 The sync word SHALL NOT be searched for while in PAYLOAD.
REQ-023 Latency: a pushed byte SHALL appear on out_data with out_valid=1 on the cycle after the 8th bit_valid when the FIFO was empty.
REQ-024 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Push while full with no pop: byte dropped, overflow set; the FSM SHALL still advance and frame_count SHALL still increment on a dropped last byte.
REQ-026 Push and pop in the same cycle while full SHALL both succeed (no overflow).
REQ-027 Pop when empty SHALL be ignored; occupancy SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-028 Reset SHALL immediately force HUNT, sreg=0, counters=0, FIFO empty, out_valid=0, out_data=0, out_last=0, sync_pulse=0, in_sync=0, overflow=0, frame_count=0.
REQ-029 Reset mid-frame SHALL discard the partial byte and all buffered bytes; hunting restarts on the first valid bit after release.

Structure
REQ-030 Package cdma_pkg SHALL hold the state enum (HUNT, PAYLOAD), the default SYNC_WORD, and the default FIFO_DEPTH.
REQ-031 The output buffer SHALL be a sub-module cdma_byte_fifo (9-bit entries: last flag + byte, with push, pop, full and empty signals).

Verification
REQ-032 Stream A5 then 01 02 03 04, out_ready=1 -> sync_pulse once; out 01,02,03,04 with out_last only on 04; frame_count=1.
REQ-033 Noise 0x5A,0xF0 then A5 + 4 bytes -> no false sync in noise; sync detected at the A5 boundary; payload correct.
REQ-034 Payload containing A5 (A5 A5 11 22 33) -> A5 delivered as data; frame ends after 33; no resync inside payload.
REQ-035 out_ready=0, two 4-byte frames -> first 4 buffered, next 4 dropped, overflow=1, frame_count=2; then out_ready=1 -> 4 bytes of frame 1 drained.
REQ-036 rst pulse after 13 payload bits -> all outputs at reset values; a following clean frame is received correctly.
REQ-037 Full FIFO with out_ready=1 at the 8th bit of the next byte -> simultaneous push/pop; overflow stays 0.
